// File: rtl/spi_regs_master_mode0_if.sv
// Command-side bus of the SPI register-access initiator: one-cycle command strobe
// with its fields, plus the busy/done/rdata status returned to the requester.
interface spi_regs_master_mode0_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;

  modport master (output start, rw, addr, wdata, input busy, done, rdata);
  modport slave  (input start, rw, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/spi_regs_master_mode0.sv
// SPI mode-0 initiator issuing one 16-bit register frame (rw, addr[6:0], data[7:0])
// per accepted command; SCLK is clk divided by 2*CLK_DIV, read byte returned in rdata.
module spi_regs_master_mode0 #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_HALVES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spi_regs_master_mode0_if.slave  cmd,
  output logic                    ss_n,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso
);
  localparam int CW      = $clog2(CLK_DIV + 1);
  localparam int GAP_CYC = GAP_HALVES * CLK_DIV - 1;
  localparam int GW      = $clog2(GAP_HALVES * CLK_DIV + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_END, ST_GAP} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [GW-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [4:0]     bit_cnt_reg, bit_cnt_next;
  logic [15:0]    shift_reg, shift_next;
  logic [7:0]     rx_reg, rx_next;
  logic           rw_reg, rw_next;
  logic           ss_n_reg, ss_n_next;
  logic           sclk_reg, sclk_next;
  logic           mosi_reg, mosi_next;
  logic           busy_reg, busy_next;
  logic           done_reg, done_next;
  logic [7:0]     rdata_reg, rdata_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      gap_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      rx_reg      <= '0;
      rw_reg      <= 1'b0;
      ss_n_reg    <= 1'b1;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      rx_reg      <= rx_next;
      rw_reg      <= rw_next;
      ss_n_reg    <= ss_n_next;
      sclk_reg    <= sclk_next;
      mosi_reg    <= mosi_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      rdata_reg   <= rdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    rx_next      = rx_reg;
    rw_next      = rw_reg;
    ss_n_next    = ss_n_reg;
    sclk_next    = sclk_reg;
    mosi_next    = mosi_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    rdata_next   = rdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cmd.start && !busy_reg) begin
          state_next   = ST_SETUP;
          ss_n_next    = 1'b0;
          busy_next    = 1'b1;
          rw_next      = cmd.rw;
          shift_next   = {cmd.rw, cmd.addr, cmd.rw ? 8'h00 : cmd.wdata};
          mosi_next    = cmd.rw;
          cnt_next     = '0;
          bit_cnt_next = '0;
        end
      end
      ST_SETUP: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next   = '0;
          state_next = ST_XFER;
          sclk_next  = 1'b1;
          rx_next    = {rx_reg[6:0], miso};
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_XFER: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next = '0;
          if (sclk_reg) begin
            // Falling edge: present the next bit; zeros shift in, so mosi ends at 0.
            sclk_next    = 1'b0;
            bit_cnt_next = bit_cnt_reg + 5'd1;
            mosi_next    = shift_reg[14];
            shift_next   = {shift_reg[14:0], 1'b0};
          end else if (bit_cnt_reg == 5'd16) begin
            state_next = ST_END;
            ss_n_next  = 1'b1;
            done_next  = 1'b1;
            if (rw_reg) begin
              rdata_next = rx_reg;
            end
          end else begin
            // Rising edge: only the last eight samples survive in rx_reg.
            sclk_next = 1'b1;
            rx_next   = {rx_reg[6:0], miso};
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_END: begin
        gap_cnt_next = '0;
        if (GAP_CYC == 0) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end else begin
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ss_n      = ss_n_reg;
  assign sclk      = sclk_reg;
  assign mosi      = mosi_reg;
  assign cmd.busy  = busy_reg;
  assign cmd.done  = done_reg;
  assign cmd.rdata = rdata_reg;
endmodule

// File: tb/tb_spi_regs_master_mode0.sv
// Scoreboard bench: two initiators (CLK_DIV=4 and CLK_DIV=1), each wired to a
// behavioural SPI register-file slave; a monitor checks every done against a queue.
module tb_spi_regs_master_mode0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]      start_d = '0, rw_d = '0;
  logic [1:0][6:0] addr_d = '0;
  logic [1:0][7:0] wdata_d = '0;
  logic [1:0]      busy_w, done_w, ss_w, sclk_w, mosi_w, miso_w;
  logic [1:0][7:0] rdata_w;

  typedef struct {
    int          inst;
    logic [15:0] frame;
    logic [7:0]  rdata;
    int          done_cyc;
    int          free_cyc;
  } sb_t;
  sb_t sbq[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int D = (gi == 0) ? 4 : 1;
    localparam int G = 2;

    spi_regs_master_mode0_if cif ();
    assign cif.start   = start_d[gi];
    assign cif.rw      = rw_d[gi];
    assign cif.addr    = addr_d[gi];
    assign cif.wdata   = wdata_d[gi];
    assign busy_w[gi]  = cif.busy;
    assign done_w[gi]  = cif.done;
    assign rdata_w[gi] = cif.rdata;

    spi_regs_master_mode0 #(.CLK_DIV(D), .GAP_HALVES(G)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .cmd  (cif),
      .ss_n (ss_w[gi]),
      .sclk (sclk_w[gi]),
      .mosi (mosi_w[gi]),
      .miso (miso_w[gi])
    );

    // Behavioural register-file slave: addr known after 8 rises, write commits on 16th fall.
    logic [7:0]  mem [128];
    logic [15:0] sh_in = '0;
    logic [7:0]  dout = '0;
    int          nrise = 0, nfall = 0;

    initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      if (gi == 1) mem[0] = 8'hC3;
    end

    always @(negedge ss_w[gi]) begin
      nrise = 0;
      nfall = 0;
    end
    always @(posedge sclk_w[gi]) if (ss_w[gi] === 1'b0) begin
      sh_in = {sh_in[14:0], mosi_w[gi]};
      nrise++;
    end
    always @(negedge sclk_w[gi]) if (ss_w[gi] === 1'b0) begin
      nfall++;
      if (nfall == 8) dout = sh_in[7] ? mem[sh_in[6:0]] : 8'h00;
      else if (nfall > 8) dout = {dout[6:0], 1'b0};
      if (nfall == 16 && !sh_in[15]) mem[sh_in[14:8]] = sh_in[7:0];
    end
    assign miso_w[gi] = dout[7];

    // Monitor
    int  free_exp = 0, hi_run = 0;
    bit  free_pend = 0, seen = 0, prev_busy = 0, prev_ss = 1;
    sb_t e;
    always @(negedge clk) if (rst_n) begin
      if (ss_w[gi]) chk("sclk_idle_low", {31'd0, sclk_w[gi]}, 0);
      if (ss_w[gi]) hi_run++;
      else if (prev_ss) begin
        if (seen) chk("ss_gap_ge", {31'd0, hi_run >= G * D}, 1);
        seen = 1;
        hi_run = 0;
      end
      if (done_w[gi]) begin
        chk("done_expected", {31'd0, sbq.size() > 0}, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("done_inst", gi, e.inst);
          chk("done_cycle", cyc, e.done_cyc);
          chk("rdata", {24'd0, rdata_w[gi]}, {24'd0, e.rdata});
          chk("mosi_frame", {16'd0, sh_in}, {16'd0, e.frame});
          chk("sclk_rises", nrise, 16);
          chk("ss_n_at_done", {31'd0, ss_w[gi]}, 1);
          chk("mosi_after_frame", {31'd0, mosi_w[gi]}, 0);
          free_exp  = e.free_cyc;
          free_pend = 1;
        end
      end
      if (prev_busy && !busy_w[gi] && free_pend) begin
        chk("busy_fall_cycle", cyc, free_exp);
        free_pend = 0;
      end
      prev_busy = busy_w[gi];
      prev_ss   = ss_w[gi];
    end
  end

  task automatic drive_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) drive_cycle();
  endtask

  // Issue one command in the current cycle; fields are scrambled right after acceptance.
  task automatic cmd(int i, logic rw, logic [6:0] a, logic [7:0] wd,
                     logic [15:0] frame, logic [7:0] exp_rd, bit expect_done);
    int dn, fr;
    dn = (i == 0) ? 133 : 34;
    fr = (i == 0) ? 141 : 36;
    start_d[i] = 1'b1; rw_d[i] = rw; addr_d[i] = a; wdata_d[i] = wd;
    if (expect_done) sbq.push_back('{i, frame, exp_rd, cyc + dn, cyc + fr});
    drive_cycle();
    start_d[i] = 1'b0; rw_d[i] = ~rw; addr_d[i] = ~a; wdata_d[i] = ~wd;
  endtask

  int c0;
  initial begin
    repeat (3) drive_cycle();
    chk("rst_ss_n", {31'd0, ss_w[0]}, 1);
    chk("rst_sclk", {31'd0, sclk_w[0]}, 0);
    chk("rst_mosi", {31'd0, mosi_w[0]}, 0);
    chk("rst_busy", {31'd0, busy_w[0]}, 0);
    chk("rst_done", {31'd0, done_w[0]}, 0);
    chk("rst_rdata", {24'd0, rdata_w[0]}, 0);
    rst_n = 1'b1;
    repeat (3) drive_cycle();

    // Write 0x12 <- 0xA5
    c0 = cyc;
    cmd(0, 1'b0, 7'h12, 8'hA5, 16'h12A5, 8'h00, 1);
    wait_until(c0 + 141);
    chk("slave_reg12", {24'd0, g_inst[0].mem[7'h12]}, 32'hA5);

    // Read back 0x12
    c0 = cyc;
    cmd(0, 1'b1, 7'h12, 8'h77, 16'h9200, 8'hA5, 1);
    wait_until(c0 + 141);

    // Write 0x05 <- 0x5A with a stray start at cycle 50
    c0 = cyc;
    cmd(0, 1'b0, 7'h05, 8'h5A, 16'h055A, 8'hA5, 1);
    wait_until(c0 + 50);
    start_d[0] = 1'b1; rw_d[0] = 1'b0; addr_d[0] = 7'h01; wdata_d[0] = 8'hFF;
    drive_cycle();
    start_d[0] = 1'b0;
    wait_until(c0 + 141);
    chk("stray_reg01", {24'd0, g_inst[0].mem[7'h01]}, 0);

    // Back-to-back with start held: write 0x7F <- 0x3C, then read 0x7F
    c0 = cyc;
    start_d[0] = 1'b1; rw_d[0] = 1'b0; addr_d[0] = 7'h7F; wdata_d[0] = 8'h3C;
    sbq.push_back('{0, 16'h7F3C, 8'hA5, c0 + 133, c0 + 141});
    drive_cycle();
    rw_d[0] = 1'b1; wdata_d[0] = 8'hEE;
    sbq.push_back('{0, 16'hFF00, 8'h3C, c0 + 274, c0 + 282});
    wait_until(c0 + 142);
    start_d[0] = 1'b0;
    wait_until(c0 + 282);

    // Reset in the middle of a write to 0x20
    c0 = cyc;
    cmd(0, 1'b0, 7'h20, 8'h99, 16'h2099, 8'h00, 0);
    wait_until(c0 + 60);
    rst_n = 1'b0;
    #1;
    chk("abort_ss_n", {31'd0, ss_w[0]}, 1);
    chk("abort_sclk", {31'd0, sclk_w[0]}, 0);
    chk("abort_mosi", {31'd0, mosi_w[0]}, 0);
    chk("abort_busy", {31'd0, busy_w[0]}, 0);
    chk("abort_rdata", {24'd0, rdata_w[0]}, 0);
    drive_cycle();
    rst_n = 1'b1;
    repeat (12) drive_cycle();
    chk("abort_reg20", {24'd0, g_inst[0].mem[7'h20]}, 0);

    // Next command after the abort: read 0x05
    c0 = cyc;
    cmd(0, 1'b1, 7'h05, 8'h11, 16'h8500, 8'h5A, 1);
    wait_until(c0 + 145);

    // CLK_DIV=1 instance: read preloaded 0x00
    c0 = cyc;
    cmd(1, 1'b1, 7'h00, 8'h5A, 16'h8000, 8'hC3, 1);
    wait_until(c0 + 40);

    chk("reg7f", {24'd0, g_inst[0].mem[7'h7F]}, 32'h3C);
    chk("reg05", {24'd0, g_inst[0].mem[7'h05]}, 32'h5A);
    chk("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
